// File: rtl/bcd_sequencer.sv
// bcd_sequencer: binary-to-BCD conversion by sequencing an external divide-by-10 datapath
module bcd_sequencer #(
    parameter int NDIG   = 4,
    parameter int MAXVAL = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [13:0] bin,
    output logic        ready,
    output logic        valid,
    output logic [15:0] bcd,
    output logic        ovf,
    output logic        div_load_value,
    output logic        div_load_quot,
    output logic [13:0] div_value,
    input  logic        div_carry,
    input  logic [13:0] div_remainder
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    state_t      state, state_next;
    logic [1:0]  idx;
    logic [15:0] digits, digits_next;
    logic        flag;
    logic        last;
    assign ready = state == IDLE;
    assign valid = state == DONE;
    assign last  = idx == 2'(NDIG - 1);
    // Next state, divider handshake and same-cycle digit capture when the divider stops carrying
    always_comb begin
        state_next     = state;
        digits_next    = digits;
        div_load_value = 1'b0;
        div_load_quot  = 1'b0;
        case (state)
            IDLE: state_next = start ? LOAD : IDLE;
            LOAD: begin
                div_load_value = !flag;
                state_next     = flag ? DONE : RUN;
            end
            RUN: if (!div_carry) begin
                digits_next[{idx, 2'b00} +: 4] = div_remainder[3:0];
                div_load_quot                  = !last;
                state_next                     = last ? DONE : RUN;
            end
            default: state_next = IDLE;
        endcase
    end
    // State, operand latch, digit index and result registers; results land as DONE is entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            digits    <= '0;
            flag      <= 1'b0;
            div_value <= '0;
            bcd       <= '0;
            ovf       <= 1'b0;
        end else begin
            state  <= state_next;
            digits <= digits_next;
            if (state == IDLE && start) begin
                div_value <= bin;
                idx       <= '0;
                digits    <= '0;
                flag      <= bin > 14'(MAXVAL);
            end
            if (state == RUN && !div_carry && !last)
                idx <= idx + 2'd1;
            if (state_next == DONE && state != DONE) begin
                bcd <= flag ? 16'hFFFF : digits_next;
                ovf <= flag;
            end
        end
    end
endmodule

// File: tb/tb_bcd_sequencer.sv
// tb_bcd_sequencer: directed scoreboard bench for bcd_sequencer with a behavioural divider
module tb_bcd_sequencer;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [13:0] bin;
    logic        ready, valid, ovf;
    logic [15:0] bcd;
    logic        div_load_value, div_load_quot, div_carry;
    logic [13:0] div_value, div_remainder;

    bcd_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .ready(ready), .valid(valid), .bcd(bcd), .ovf(ovf),
        .div_load_value(div_load_value), .div_load_quot(div_load_quot),
        .div_value(div_value), .div_carry(div_carry), .div_remainder(div_remainder)
    );

    always #5 clk = ~clk;

    // Repeated-subtraction divider: load resets the quotient, otherwise subtract 10 every cycle
    logic [13:0] dvd = '0;
    logic [9:0]  quo = '0;
    assign div_carry     = dvd >= 14'd10;
    assign div_remainder = dvd;
    always @(posedge clk) begin
        if (div_load_value) begin
            dvd <= div_value;
            quo <= '0;
        end else if (div_load_quot) begin
            dvd <= {4'b0, quo};
            quo <= '0;
        end else begin
            dvd <= dvd - 14'd10;
            quo <= quo + 10'd1;
        end
    end

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        int          lat;
        int          t0;
    } exp_t;
    exp_t exp_q[$];

    int total = 0, bad = 0, cyc = 0, nload = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, obs, want);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: every valid pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (!rst && div_load_value) nload++;
        if (!rst && valid) begin
            check("valid_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("bcd", 32'(bcd), 32'(e.bcd));
                check("ovf", 32'(ovf), 32'(e.ovf));
                check("latency", 32'(cyc - e.t0), 32'(e.lat));
            end
        end
    end

    function automatic exp_t model(input int v);
        exp_t e;
        int   d;
        e.t0 = 0;
        if (v > 9999) begin
            e.bcd = 16'hFFFF;
            e.ovf = 1'b1;
            e.lat = 2;
        end else begin
            e.ovf = 1'b0;
            e.lat = 2;
            d     = v;
            for (int i = 0; i < 4; i++) begin
                e.bcd[i*4 +: 4] = 4'(d % 10);
                e.lat += d / 10 + 1;
                d = d / 10;
            end
        end
        return e;
    endfunction

    task automatic push(input int v);
        exp_t e;
        e    = model(v);
        e.t0 = cyc;
        exp_q.push_back(e);
    endtask

    task automatic go(input int v);
        @(negedge clk);
        bin   = 14'(v);
        start = 1'b1;
        push(v);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !ready) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("wait_timeout", 32'(n < 3000), 32'd1);
    endtask

    initial begin
        int n0;
        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_bcd", 32'(bcd), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_lv", 32'(div_load_value), 32'd0);
        check("rst_lq", 32'(div_load_quot), 32'd0);
        check("rst_dv", 32'(div_value), 32'd0);
        rst = 1'b0;
        go(0);     wait_idle();
        go(1234);  wait_idle();
        go(9999);  wait_idle();
        n0 = nload;
        go(10000); wait_idle();
        check("ovf_no_load", 32'(nload), 32'(n0));
        @(negedge clk);
        bin   = 14'd7;
        start = 1'b1;
        push(7);
        repeat (3) begin
            @(negedge clk);
            bin = 14'd123;
            check("busy_ready", 32'(ready), 32'd0);
        end
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        check("busy_ready_back", 32'(ready), 32'd1);
        check("bcd_held", 32'(bcd), 32'h0007);
        check("no_extra_result", 32'(exp_q.size()), 32'd0);
        go(5000);
        repeat (20) @(negedge clk);
        check("run_busy", 32'(ready), 32'd0);
        #2 rst = 1'b1;
        exp_q.delete();
        #1;
        check("arst_ready", 32'(ready), 32'd1);
        check("arst_valid", 32'(valid), 32'd0);
        check("arst_bcd", 32'(bcd), 32'd0);
        check("arst_ovf", 32'(ovf), 32'd0);
        check("arst_lv", 32'(div_load_value), 32'd0);
        check("arst_lq", 32'(div_load_quot), 32'd0);
        check("arst_dv", 32'(div_value), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        go(42);    wait_idle();
        check("final_bcd", 32'(bcd), 32'h0042);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
